// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic array: loads accumulator rows, streams skewed operands, reads results.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_cycles / perf_stalls counters.
module systolic_ctrl #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3*DIM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic [DIM-1:0]          feed_mask,
    output logic [CNT_W-1:0]        k_idx,
    output logic                    arr_en,
    output logic [DIM-1:0]          wr_row,
    output logic [$clog2(DIM)-1:0]  c_row,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stalls
`endif
);

    localparam int ROW_W = $clog2(DIM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOADC   = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] K_ROW_LAST  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] K_STEP_LAST = CNT_W'(3*DIM - 3);
    localparam logic [DIM-1:0]   ROW_ONE     = {{(DIM-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [CNT_W-1:0] k;

    // k restarts at zero on every state entry, so each terminal compare is local to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOADC;
                        k     <= '0;
                    end
                end
                S_LOADC: begin
                    if (k == K_ROW_LAST) begin
                        state <= S_COMPUTE;
                        k     <= '0;
                    end else begin
                        k <= k + CNT_W'(1);
                    end
                end
                S_COMPUTE: begin
                    if (src_valid) begin
                        if (k == K_STEP_LAST) begin
                            state <= S_READ;
                            k     <= '0;
                        end else begin
                            k <= k + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        if (k == K_ROW_LAST) begin
                            state <= S_DONE;
                            k     <= '0;
                        end else begin
                            k <= k + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    k     <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

    // Outputs decode only registered state; src_valid -> arr_en is the one intended comb path
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        src_ready = 1'b0;
        feed_mask = '0;
        k_idx     = k;
        arr_en    = 1'b0;
        wr_row    = '0;
        c_row     = '0;
        out_valid = 1'b0;
        case (state)
            S_LOADC: begin
                arr_en = 1'b1;
                wr_row = ROW_ONE << k;
                c_row  = k[ROW_W-1:0];
            end
            S_COMPUTE: begin
                src_ready = 1'b1;
                arr_en    = src_valid;
                for (int i = 0; i < DIM; i++) begin
                    feed_mask[i] = (int'(k) >= i) && ((int'(k) - i) < DIM);
                end
            end
            S_READ: begin
                out_valid = 1'b1;
                c_row     = k[ROW_W-1:0];
            end
            default: begin
            end
        endcase
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic stall_cycle;
    assign stall_cycle = ((state == S_COMPUTE) && !src_valid) ||
                         ((state == S_READ) && !out_ready);

    // Counters clear when a run is accepted and freeze once back in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if ((state != S_IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (stall_cycle && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
